bcd_countdown_timer: RTL and testbench

//  Two-digit BCD countdown timer, 00..99 s, driving HEX1 (tens) and HEX0 (ones).

---
 rtl/bcd_countdown_timer.sv | 119 +++++++++++
 tb/tb_bcd_countdown_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (00..99) with a 1 s prescaler and active-low
// 7-segment decode of both digits onto HEX1 (tens) and HEX0 (ones).
module bcd_countdown_timer #(
    parameter int TICK_COUNT = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       load,
    input  logic [7:0] preset_bcd,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_COUNT - 1);

    state_t        state, state_n;
    logic [3:0]    tens_n, ones_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic [3:0]    dec_tens, dec_ones;
    logic [3:0]    pre_tens, pre_ones;
    logic          tick;
    logic          nonzero;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign tick     = (state == RUN) && (prescaler == PS_LAST);
    assign nonzero  = (tens != 4'd0) || (ones != 4'd0);
    assign pre_tens = (preset_bcd[7:4] > 4'd9) ? 4'd9 : preset_bcd[7:4];
    assign pre_ones = (preset_bcd[3:0] > 4'd9) ? 4'd9 : preset_bcd[3:0];

    // BCD borrow: ones wraps to 9 and borrows from tens, never via 0xF.
    always_comb begin
        dec_ones = ones - 4'd1;
        dec_tens = tens;
        if (ones == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens - 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state     <= IDLE;
            tens      <= 4'd0;
            ones      <= 4'd0;
            prescaler <= '0;
        end else begin
            state     <= state_n;
            tens      <= tens_n;
            ones      <= ones_n;
            prescaler <= prescaler_n;
        end
    end

    // The prescaler advances on every RUN edge, including the one that sees
    // stop, so a pause/resume loses no time within the current second.
    always_comb begin
        state_n     = state;
        tens_n      = tens;
        ones_n      = ones;
        prescaler_n = prescaler;
        if (state == RUN) begin
            prescaler_n = tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                tens_n = dec_tens;
                ones_n = dec_ones;
            end
            if (tick && dec_tens == 4'd0 && dec_ones == 4'd0)
                state_n = DONE;
            else if (stop)
                state_n = PAUSE;
        end else if (load) begin
            tens_n      = pre_tens;
            ones_n      = pre_ones;
            prescaler_n = '0;
            state_n     = IDLE;
        end else if (start && !stop && nonzero && state != DONE) begin
            state_n = RUN;
            if (state == IDLE)
                prescaler_n = '0;
        end
    end

    assign running   = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;
    assign HEX1      = seg7(tens);
    assign HEX0      = seg7(ones);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_COUNT=4; expected digits,
// flags and segment patterns are hand-derived constants.
module tb_bcd_countdown_timer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       load     = 1'b0;
    logic [7:0] preset_bcd = 8'h00;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic [3:0] tens, ones;
    logic       running, done;
    logic [0:6] HEX1, HEX0;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    bcd_countdown_timer #(.TICK_COUNT(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .load       (load),
        .preset_bcd (preset_bcd),
        .start      (start),
        .stop       (stop),
        .tens       (tens),
        .ones       (ones),
        .running    (running),
        .done       (done),
        .HEX1       (HEX1),
        .HEX0       (HEX0),
        .state_dbg  (state_dbg)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] p);
        preset_bcd = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic check_val(input string tag, input int v, input logic [1:0] st);
        logic [7:0] exp;
        exp = 8'((v / 10) * 16 + (v % 10));
        check({tag, "_val"}, {tens, ones}, exp);
        check({tag, "_st"}, state_dbg, st);
    endtask

    initial begin
        int v;

        // 1: reset
        step(2);
        check("rst_tens", tens, 4'd0);
        check("rst_ones", ones, 4'd0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hex1", HEX1, 7'b0000001);
        check("rst_hex0", HEX0, 7'b0000001);
        check("rst_state", state_dbg, S_IDLE);
        Resetn = 1'b1;
        step();

        // 2: 12 -> 00, then hold
        do_load(8'h12);
        check_val("t2_load", 12, S_IDLE);
        pulse_start();
        check_val("t2_start", 12, S_RUN);
        for (int k = 1; k <= 68; k++) begin
            step();
            v = (k >= 48) ? 0 : 12 - k / 4;
            check("t2_val", {tens, ones}, 8'((v / 10) * 16 + (v % 10)));
            check("t2_running", running, (k < 48) ? 1'b1 : 1'b0);
            check("t2_done", done, (k >= 48) ? 1'b1 : 1'b0);
            if (k % 4 == 0) begin
                check("t2_hex0", HEX0, seg_tab[v % 10]);
                check("t2_hex1", HEX1, seg_tab[v / 10]);
            end
        end

        // 3: BCD borrow 10 -> 09
        do_load(8'h10);
        check("t3_done_clr", done, 1'b0);
        pulse_start();
        step(3);
        check_val("t3_pre", 10, S_RUN);
        step();
        check_val("t3_borrow", 9, S_RUN);
        check("t3_hex1", HEX1, 7'b0000001);
        check("t3_hex0", HEX0, 7'b0000100);
        pulse_stop();
        check_val("t3_pause", 9, S_PAUSE);

        // 4: pause/resume keeps partial second; tick+stop cases
        do_load(8'h05);
        check_val("t4_load", 5, S_IDLE);
        pulse_start();
        step(5);
        check_val("t4_dec", 4, S_RUN);
        pulse_stop();
        check_val("t4_stop", 4, S_PAUSE);
        step(20);
        check_val("t4_hold", 4, S_PAUSE);
        pulse_start();
        check_val("t4_resume", 4, S_RUN);
        step();
        check_val("t4_r1", 4, S_RUN);
        step();
        check_val("t4_r2", 3, S_RUN);
        step(3);
        check_val("t4_pre_tick", 3, S_RUN);
        pulse_stop();
        check_val("t4_tick_stop", 2, S_PAUSE);
        pulse_start();
        step(4);
        check_val("t4_r3", 1, S_RUN);
        step(3);
        pulse_stop();
        check_val("t4_stop_zero", 0, S_DONE);
        check("t4_done", done, 1'b1);
        pulse_start();
        check_val("t4_start_done", 0, S_DONE);

        // 5: clamp and load ignored while running
        do_load(8'hAF);
        check_val("t5_clamp", 99, S_IDLE);
        check("t5_hex1", HEX1, 7'b0000100);
        pulse_start();
        step(2);
        preset_bcd = 8'h33;
        load = 1'b1;
        step();
        load = 1'b0;
        check_val("t5_load_ign", 99, S_RUN);
        step();
        check_val("t5_cont", 98, S_RUN);

        // 6: reset mid-run, start+stop together, start at 00
        pulse_stop();
        do_load(8'h08);
        check_val("t6_load", 8, S_IDLE);
        pulse_start();
        step(5);
        check_val("t6_at7", 7, S_RUN);
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        check_val("t6_rst", 0, S_IDLE);
        check("t6_running", running, 1'b0);
        check("t6_hex0", HEX0, 7'b0000001);
        do_load(8'h07);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_val("t6_both", 7, S_IDLE);
        do_load(8'h00);
        pulse_start();
        check_val("t6_start_zero", 0, S_IDLE);
        step(4);
        check_val("t6_zero_hold", 0, S_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
